data_mem_lsu: RTL and testbench



---
 rtl/lsu_pkg.sv | 36 +++
 rtl/data_mem_lsu_align.sv | 59 +++++
 rtl/data_mem_lsu.sv | 197 +++++++++++++++++++
 tb/tb_data_mem_lsu.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 encodings,
// controller states and access-size helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    DONE = 2'd3
  } state_t;

  // Access size in bytes; bit 2 of funct3 only selects zero-extension.
  function automatic logic [2:0] size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Stores have no unsigned variants, so only B/H/W are legal for them.
  function automatic logic funct3_legal(input logic is_write, input logic [2:0] f3);
    if (is_write)
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/data_mem_lsu_align.sv
// Byte-lane steering for the LSU: store data/mask shifted into the two word
// slots, and load data extracted from a {word1,word0} pair and extended.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_word0,
  input  logic [31:0] i_word1,
  output logic        o_split,
  output logic [3:0]  o_be0,
  output logic [3:0]  o_be1,
  output logic [31:0] o_wdata0,
  output logic [31:0] o_wdata1,
  output logic [31:0] o_rdata
);

  logic [2:0]  w_size;
  logic [3:0]  w_size_mask;
  logic [7:0]  w_mask;
  logic [63:0] w_wshift;
  logic [31:0] w_rshift;

  assign w_size  = size_bytes(i_funct3);
  assign o_split = ({1'b0, i_off} + w_size) > 3'd4;

  // Contiguous lane mask for the access size before shifting by the offset.
  always_comb begin
    case (w_size)
      3'd1:    w_size_mask = 4'b0001;
      3'd2:    w_size_mask = 4'b0011;
      default: w_size_mask = 4'b1111;
    endcase
  end

  assign w_mask   = {4'b0000, w_size_mask} << i_off;
  assign w_wshift = {32'h0000_0000, i_wdata} << {i_off, 3'b000};
  assign o_be0    = w_mask[3:0];
  assign o_be1    = w_mask[7:4];
  assign o_wdata0 = w_wshift[31:0];
  assign o_wdata1 = w_wshift[63:32];

  // Only the low 32 bits of the shifted pair can ever hold the loaded bytes.
  assign w_rshift = 32'({i_word1, i_word0} >> {i_off, 3'b000});

  // Keep the low size bytes and extend according to funct3.
  always_comb begin
    o_rdata = w_rshift;
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_rshift[7]}}, w_rshift[7:0]};
      F3_BU:   o_rdata = {24'h00_0000, w_rshift[7:0]};
      F3_H:    o_rdata = {{16{w_rshift[15]}}, w_rshift[15:0]};
      F3_HU:   o_rdata = {16'h0000, w_rshift[15:0]};
      default: o_rdata = w_rshift;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit in front of a synchronous data memory. One request at a
// time; misaligned halfwords/words become two word accesses.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request, memory enables low
// ACC0  | first (or only) word access; loads hold for LAT+1 cycles
// ACC1  | second word of a split access
// DONE  | oDone (and oFault for illegal funct3) high for one cycle
module data_mem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH       = 32,
  parameter int MEM_READ_LATENCY = 1
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iReq,
  output logic                  oReady,
  input  logic                  iWrite,
  input  logic [2:0]            iFunct3,
  input  logic [ADDR_WIDTH-1:0] iAddress,
  input  logic [31:0]           iWriteData,
  output logic                  oDone,
  output logic                  oFault,
  output logic [31:0]           oReadData,
  output logic                  oMemReadEnable,
  output logic                  oMemWriteEnable,
  output logic [3:0]            oMemByteEnable,
  output logic [ADDR_WIDTH-1:0] oMemAddress,
  output logic [31:0]           oMemWriteData,
  input  logic [31:0]           iMemReadData
);

  localparam int CW = (MEM_READ_LATENCY < 1) ? 1 : $clog2(MEM_READ_LATENCY + 1);
  localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_READ_LATENCY);

  state_t          r_state;
  logic            r_write;
  logic [2:0]      r_funct3;
  logic [1:0]      r_off;
  logic [31:0]     r_wdata;
  logic [31:0]     r_word0;
  logic [CW-1:0]   r_cnt;

  logic            w_accept;
  logic            w_legal;
  logic            w_in_idle;
  logic [1:0]      w_off;
  logic [2:0]      w_funct3;
  logic [31:0]     w_wdata;
  logic [31:0]     w_word0;
  logic            w_split;
  logic [3:0]      w_be0;
  logic [3:0]      w_be1;
  logic [31:0]     w_wdata0;
  logic [31:0]     w_wdata1;
  logic [31:0]     w_rdata;

  assign w_accept  = iReq && oReady;
  assign w_legal   = funct3_legal(iWrite, iFunct3);
  assign w_in_idle = (r_state == IDLE);

  // In IDLE the aligner sees the incoming request so word0 lanes are ready at
  // the accept edge; afterwards it works from the captured fields.
  assign w_off    = w_in_idle ? iAddress[1:0] : r_off;
  assign w_funct3 = w_in_idle ? iFunct3       : r_funct3;
  assign w_wdata  = w_in_idle ? iWriteData    : r_wdata;
  // During ACC0 the live memory word is word0; in ACC1 it is word1.
  assign w_word0  = (r_state == ACC0) ? iMemReadData : r_word0;

  lsu_align u_align (
    .i_off    (w_off),
    .i_funct3 (w_funct3),
    .i_wdata  (w_wdata),
    .i_word0  (w_word0),
    .i_word1  (iMemReadData),
    .o_split  (w_split),
    .o_be0    (w_be0),
    .o_be1    (w_be1),
    .o_wdata0 (w_wdata0),
    .o_wdata1 (w_wdata1),
    .o_rdata  (w_rdata)
  );

  // Sequencing FSM with registered outputs and a down-counter for read latency.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state         <= IDLE;
      r_write         <= 1'b0;
      r_funct3        <= 3'd0;
      r_off           <= 2'd0;
      r_wdata         <= 32'h0;
      r_word0         <= 32'h0;
      r_cnt           <= '0;
      oReady          <= 1'b1;
      oDone           <= 1'b0;
      oFault          <= 1'b0;
      oReadData       <= 32'h0;
      oMemReadEnable  <= 1'b0;
      oMemWriteEnable <= 1'b0;
      oMemByteEnable  <= 4'h0;
      oMemAddress     <= '0;
      oMemWriteData   <= 32'h0;
    end else begin
      oDone  <= 1'b0;
      oFault <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_write  <= iWrite;
            r_funct3 <= iFunct3;
            r_off    <= iAddress[1:0];
            r_wdata  <= iWriteData;
            r_cnt    <= LAT_LOAD;
            oReady   <= 1'b0;
            if (!w_legal) begin
              oDone   <= 1'b1;
              oFault  <= 1'b1;
              r_state <= DONE;
            end else begin
              oMemAddress <= {iAddress[ADDR_WIDTH-1:2], 2'b00};
              r_state     <= ACC0;
              if (iWrite) begin
                oMemWriteEnable <= 1'b1;
                oMemByteEnable  <= w_be0;
                oMemWriteData   <= w_wdata0;
              end else begin
                oMemReadEnable <= 1'b1;
                oMemByteEnable <= 4'hF;
              end
            end
          end
        end
        ACC0: begin
          if (r_write) begin
            if (w_split) begin
              oMemAddress    <= oMemAddress + ADDR_WIDTH'(4);
              oMemByteEnable <= w_be1;
              oMemWriteData  <= w_wdata1;
              r_state        <= ACC1;
            end else begin
              oMemWriteEnable <= 1'b0;
              oMemByteEnable  <= 4'h0;
              oMemWriteData   <= 32'h0;
              oMemAddress     <= '0;
              oDone           <= 1'b1;
              r_state         <= DONE;
            end
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (w_split) begin
            r_word0     <= iMemReadData;
            oMemAddress <= oMemAddress + ADDR_WIDTH'(4);
            r_cnt       <= LAT_LOAD;
            r_state     <= ACC1;
          end else begin
            oReadData      <= w_rdata;
            oMemReadEnable <= 1'b0;
            oMemByteEnable <= 4'h0;
            oMemAddress    <= '0;
            oDone          <= 1'b1;
            r_state        <= DONE;
          end
        end
        ACC1: begin
          if (r_write) begin
            oMemWriteEnable <= 1'b0;
            oMemByteEnable  <= 4'h0;
            oMemWriteData   <= 32'h0;
            oMemAddress     <= '0;
            oDone           <= 1'b1;
            r_state         <= DONE;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            oReadData      <= w_rdata;
            oMemReadEnable <= 1'b0;
            oMemByteEnable <= 4'h0;
            oMemAddress    <= '0;
            oDone          <= 1'b1;
            r_state        <= DONE;
          end
        end
        DONE: begin
          oReady  <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          oReady  <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu with a one-cycle-latency memory model.
module tb_data_mem_lsu;

  logic        iCLK;
  logic        iRST;
  logic        iReq;
  logic        oReady;
  logic        iWrite;
  logic [2:0]  iFunct3;
  logic [31:0] iAddress;
  logic [31:0] iWriteData;
  logic        oDone;
  logic        oFault;
  logic [31:0] oReadData;
  logic        oMemReadEnable;
  logic        oMemWriteEnable;
  logic [3:0]  oMemByteEnable;
  logic [31:0] oMemAddress;
  logic [31:0] oMemWriteData;
  logic [31:0] iMemReadData;

  int checks = 0;
  int errors = 0;

  data_mem_lsu #(.ADDR_WIDTH(32), .MEM_READ_LATENCY(1)) dut (
    .iCLK            (iCLK),
    .iRST            (iRST),
    .iReq            (iReq),
    .oReady          (oReady),
    .iWrite          (iWrite),
    .iFunct3         (iFunct3),
    .iAddress        (iAddress),
    .iWriteData      (iWriteData),
    .oDone           (oDone),
    .oFault          (oFault),
    .oReadData       (oReadData),
    .oMemReadEnable  (oMemReadEnable),
    .oMemWriteEnable (oMemWriteEnable),
    .oMemByteEnable  (oMemByteEnable),
    .oMemAddress     (oMemAddress),
    .oMemWriteData   (oMemWriteData),
    .iMemReadData    (iMemReadData)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h1001_0000: return 32'h4433_8000;
      32'h1001_0004: return 32'h7788_6655;
      default:       return 32'h0000_0000;
    endcase
  endfunction

  // Synchronous read, one cycle of latency.
  always @(posedge iCLK) iMemReadData <= mem_word(oMemAddress);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request in the current (IDLE) cycle; returns at the sample point
  // of the cycle after the accept edge.
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
    iReq = 1'b1; iWrite = w; iFunct3 = f3; iAddress = a; iWriteData = d;
    @(negedge iCLK);
    iReq = 1'b0; iWrite = 1'b0; iFunct3 = 3'd0; iAddress = 32'h0; iWriteData = 32'h0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, {31'b0, oReady}, 32'd1);
    chk({tag, "_done_low"}, {31'b0, oDone}, 32'd0);
  endtask

  initial begin
    iRST = 1'b1; iReq = 1'b0; iWrite = 1'b0; iFunct3 = 3'd0;
    iAddress = 32'h0; iWriteData = 32'h0; iMemReadData = 32'h0;
    repeat (3) @(negedge iCLK);
    iRST = 1'b0;
    chk("rst_ready", {31'b0, oReady}, 32'd1);
    chk("rst_done", {31'b0, oDone}, 32'd0);
    chk("rst_fault", {31'b0, oFault}, 32'd0);
    chk("rst_rdata", oReadData, 32'h0);
    chk("rst_en", {30'b0, oMemReadEnable, oMemWriteEnable}, 32'd0);
    chk("rst_addr", oMemAddress, 32'h0);
    chk("rst_be", {28'b0, oMemByteEnable}, 32'h0);

    // SW aligned
    issue(1'b1, 3'd2, 32'h1001_0004, 32'hDEAD_BEEF);
    chk("sw_we", {30'b0, oMemReadEnable, oMemWriteEnable}, 32'd1);
    chk("sw_addr", oMemAddress, 32'h1001_0004);
    chk("sw_be", {28'b0, oMemByteEnable}, 32'hF);
    chk("sw_data", oMemWriteData, 32'hDEAD_BEEF);
    chk("sw_busy", {31'b0, oReady}, 32'd0);
    @(negedge iCLK);
    chk("sw_done", {31'b0, oDone}, 32'd1);
    chk("sw_we_off", {30'b0, oMemReadEnable, oMemWriteEnable}, 32'd0);
    chk("sw_rdata_hold", oReadData, 32'h0);
    @(negedge iCLK);
    chk_idle("sw_end");

    // SB offset 3
    issue(1'b1, 3'd0, 32'h1001_0003, 32'h0000_00AB);
    chk("sb_addr", oMemAddress, 32'h1001_0000);
    chk("sb_be", {28'b0, oMemByteEnable}, 32'b1000);
    chk("sb_data", oMemWriteData, 32'hAB00_0000);
    @(negedge iCLK);
    chk("sb_done", {31'b0, oDone}, 32'd1);
    @(negedge iCLK);
    chk_idle("sb_end");

    // LB sign-extended
    issue(1'b0, 3'd0, 32'h1001_0001, 32'h0);
    chk("lb_re", {30'b0, oMemReadEnable, oMemWriteEnable}, 32'd2);
    chk("lb_addr", oMemAddress, 32'h1001_0000);
    chk("lb_be", {28'b0, oMemByteEnable}, 32'hF);
    @(negedge iCLK);
    chk("lb_re_hold", {30'b0, oMemReadEnable, oMemWriteEnable}, 32'd2);
    chk("lb_not_done", {31'b0, oDone}, 32'd0);
    @(negedge iCLK);
    chk("lb_done", {31'b0, oDone}, 32'd1);
    chk("lb_rdata", oReadData, 32'hFFFF_FF80);
    chk("lb_re_off", {30'b0, oMemReadEnable, oMemWriteEnable}, 32'd0);
    @(negedge iCLK);
    chk_idle("lb_end");

    // LBU same address
    issue(1'b0, 3'd4, 32'h1001_0001, 32'h0);
    repeat (2) @(negedge iCLK);
    chk("lbu_done", {31'b0, oDone}, 32'd1);
    chk("lbu_rdata", oReadData, 32'h0000_0080);
    @(negedge iCLK);

    // LH sign-extended, aligned
    issue(1'b0, 3'd1, 32'h1001_0000, 32'h0);
    repeat (2) @(negedge iCLK);
    chk("lh_rdata", oReadData, 32'hFFFF_8000);
    @(negedge iCLK);

    // LHU offset 2
    issue(1'b0, 3'd5, 32'h1001_0002, 32'h0);
    repeat (2) @(negedge iCLK);
    chk("lhu_done", {31'b0, oDone}, 32'd1);
    chk("lhu_rdata", oReadData, 32'h0000_4433);
    @(negedge iCLK);

    // LW split across two words
    issue(1'b0, 3'd2, 32'h1001_0002, 32'h0);
    chk("lw2_addr0", oMemAddress, 32'h1001_0000);
    @(negedge iCLK);
    chk("lw2_addr0_hold", oMemAddress, 32'h1001_0000);
    chk("lw2_re0", {30'b0, oMemReadEnable, oMemWriteEnable}, 32'd2);
    @(negedge iCLK);
    chk("lw2_addr1", oMemAddress, 32'h1001_0004);
    chk("lw2_be1", {28'b0, oMemByteEnable}, 32'hF);
    chk("lw2_not_done", {31'b0, oDone}, 32'd0);
    @(negedge iCLK);
    chk("lw2_re1", {30'b0, oMemReadEnable, oMemWriteEnable}, 32'd2);
    chk("lw2_not_done2", {31'b0, oDone}, 32'd0);
    @(negedge iCLK);
    chk("lw2_done", {31'b0, oDone}, 32'd1);
    chk("lw2_rdata", oReadData, 32'h6655_4433);
    @(negedge iCLK);
    chk_idle("lw2_end");

    // SH split with address wrap
    issue(1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0000_1234);
    chk("sh_addr0", oMemAddress, 32'hFFFF_FFFC);
    chk("sh_be0", {28'b0, oMemByteEnable}, 32'b1000);
    chk("sh_data0", oMemWriteData, 32'h3400_0000);
    chk("sh_we0", {30'b0, oMemReadEnable, oMemWriteEnable}, 32'd1);
    @(negedge iCLK);
    chk("sh_addr1", oMemAddress, 32'h0000_0000);
    chk("sh_be1", {28'b0, oMemByteEnable}, 32'b0001);
    chk("sh_data1", oMemWriteData, 32'h0000_0012);
    chk("sh_we1", {30'b0, oMemReadEnable, oMemWriteEnable}, 32'd1);
    chk("sh_not_done", {31'b0, oDone}, 32'd0);
    @(negedge iCLK);
    chk("sh_done", {31'b0, oDone}, 32'd1);
    chk("sh_we_off", {30'b0, oMemReadEnable, oMemWriteEnable}, 32'd0);
    chk("sh_rdata_hold", oReadData, 32'h6655_4433);
    @(negedge iCLK);

    // Illegal load funct3
    issue(1'b0, 3'd3, 32'h1001_0000, 32'h0);
    chk("fl_done", {31'b0, oDone}, 32'd1);
    chk("fl_fault", {31'b0, oFault}, 32'd1);
    chk("fl_en", {30'b0, oMemReadEnable, oMemWriteEnable}, 32'd0);
    chk("fl_rdata_hold", oReadData, 32'h6655_4433);
    @(negedge iCLK);
    chk("fl_fault_pulse", {31'b0, oFault}, 32'd0);
    chk_idle("fl_end");

    // Illegal store funct3
    issue(1'b1, 3'd4, 32'h1001_0000, 32'h1);
    chk("fs_fault", {31'b0, oFault}, 32'd1);
    chk("fs_en", {30'b0, oMemReadEnable, oMemWriteEnable}, 32'd0);
    @(negedge iCLK);

    // Reset during ACC1 of a split LW
    issue(1'b0, 3'd2, 32'h1001_0001, 32'h0);
    @(negedge iCLK);
    @(negedge iCLK);
    chk("rstmid_acc1_addr", oMemAddress, 32'h1001_0004);
    chk("rstmid_acc1_re", {30'b0, oMemReadEnable, oMemWriteEnable}, 32'd2);
    iRST = 1'b1;
    @(negedge iCLK);
    iRST = 1'b0;
    chk("rstmid_en", {30'b0, oMemReadEnable, oMemWriteEnable}, 32'd0);
    chk("rstmid_ready", {31'b0, oReady}, 32'd1);
    chk("rstmid_rdata", oReadData, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("rstmid_no_done", {31'b0, oDone}, 32'd0);
      @(negedge iCLK);
    end

    // Unit usable after abort
    issue(1'b0, 3'd2, 32'h1001_0004, 32'h0);
    repeat (2) @(negedge iCLK);
    chk("post_done", {31'b0, oDone}, 32'd1);
    chk("post_rdata", oReadData, 32'h7788_6655);
    @(negedge iCLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
